bicubic_line_scaler: RTL
========================

// Module: bicubic_line_scaler
// PURPOSE
//  Parametrised 1-D scaler for the bicubic upscaler datapath.
//  - Buffers one source row of SW pixels, then emits TW interpolated pixels.
//  - Source position of output k is x = k*(SW-1)/(TW-1); ends map exactly to p[0] and p[SW-1].
//  - Run-time mode: Catmull-Rom bicubic or bilinear.
//  - Valid/ready streams replace direct ROM/SRAM addressing, so rows feed a column pass or a result memory.
// PARAMETERS
//  PIX_W   8   pixel width (unsigned)
//  FRAC_W  16  fractional bits of t and of the Horner accumulator
//  MAX_SW  32  line-buffer depth, max source width
//  MAX_TW  64  max target width
// PORTS
//  CLK        in   1                     clock, rising edge
//  RST        in   1                     synchronous active-high reset
//  start      in   1                     pulse; latches cfg_sw/cfg_tw/mode when IDLE
//  cfg_sw     in   $clog2(MAX_SW+1)      source width SW, legal range 2..MAX_SW
//  cfg_tw     in   $clog2(MAX_TW+1)      target width TW, legal range 2..MAX_TW
//  mode       in   1                     0 = bicubic (Catmull-Rom, a=-0.5); 1 = bilinear
//  in_valid   in   1                     source pixel valid
//  in_ready   out  1                     high only in LOAD
//  in_data    in   PIX_W                 source pixel, raster order
//  out_valid  out  1                     result valid
//  out_ready  in   1                     sink accepts result
//  out_data   out  PIX_W                 interpolated pixel
//  busy       out  1                     state != IDLE
//  done       out  1                     1-cycle pulse after last output handshake
//  cfg_err    out  1                     1-cycle pulse when start carries illegal SW/TW
// BEHAVIOUR
//  Reset: all outputs 0. State goes to IDLE; counters, idx, rem and acc are cleared.
//   RST mid-operation aborts the row; no further out_valid until the next start.
//  FSM:
//   IDLE -start&legal-> LOAD
//     - start with illegal SW/TW: cfg_err=1 next cycle; stay IDLE.
//     - start outside IDLE: ignored.
//   LOAD: accepts a beat on in_valid&in_ready into buf[n]; n counts 0..SW-1.
//     - After beat SW-1 -> STEP with k=0, idx=0, rem=0.
//   STEP: k>0 -> rem += SW-1 (1 cycle). Then 1 cycle per (rem>=TW-1: rem -= TW-1, idx++) -> DIV.
//     - k=0: skips the add.
//   DIV: restoring divide, exactly FRAC_W cycles -> t = floor(rem*2^FRAC_W/(TW-1)) -> CALC.
//   CALC: exactly 4 cycles, Horner scheme:
//     acc=a; acc=acc*t+b; acc=acc*t+c; acc=acc*t+d; then round and clamp -> OUT.
//   OUT: out_valid=1, out_data stable until out_ready.
//     - On handshake: k<TW-1 -> k++, STEP. Else -> DONE.
//   DONE: done=1 for 1 cycle -> IDLE.
//  Taps: p0=buf[idx-1], p1=buf[idx], p2=buf[idx+1], p3=buf[idx+2].
//   - Indices are clamped to 0..SW-1, i.e. edge pixels are replicated.
//  Coefficients, signed, 1 fractional bit, width PIX_W+4:
//   - Bicubic: a=(-p0+3p1-3p2+p3)/2; b=p0-5p1/2+2p2-p3/2; c=(p2-p0)/2; d=p1.
//   - Bilinear: a=b=0; c=p2-p1; d=p1. CALC still takes 4 cycles.
//  Arithmetic:
//   - acc is signed, PIX_W+5 integer bits plus FRAC_W fractional bits.
//   - Each product is truncated back to FRAC_W fractional bits.
//  Output:
//   - Round half-up at FRAC_W-1.
//   - Clamp: negative -> 0; value > 2^PIX_W-1 -> 2^PIX_W-1.
//  t=0 (rem=0) yields exactly p1. Output k=TW-1 always yields buf[SW-1].
//  SW>TW (downscale) is legal; STEP then takes several subtract cycles.
//  in_valid outside LOAD: ignored, no data consumed.
// TESTING
//  1) SW=4, TW=7, mode=0, in {10,20,30,40} -> out 10,14,20,25,30,36,40; done once.
//  2) Same row, mode=1 -> out 10,15,20,25,30,35,40.
//  3) SW=4, TW=7, mode=0, in {0,255,255,0} -> out[3]=255 (raw 286.875, clamped).
//     out[0]=0, out[6]=0.
//  4) SW=7, TW=4, in {0,10,..,60} -> out 0,20,40,60 (t=0 each; downscale path).
//  5) Test 1 with out_ready low 5 cycles on k=2 -> out_data holds 20; no output lost or repeated.
//  6) RST during CALC of k=3 -> all outputs 0, busy=0; fresh start runs test 1 cleanly.
//     start with SW=1 -> cfg_err pulse, in_ready stays 0.

Source files
------------

// File: rtl/bicubic_line_scaler_if.sv
// rtl/bicubic_line_scaler_if.sv - handshake/config bundle for bicubic_line_scaler
// Purpose: groups the start/config pulse, source pixel stream, result stream
//          and status pulses of the 1-D scaler into one port.
// Signals: start/cfg_sw/cfg_tw/mode  row configuration, latched on start in IDLE
//          in_valid/in_ready/in_data    source pixel stream (raster order)
//          out_valid/out_ready/out_data interpolated pixel stream
//          busy/done/cfg_err            status
// Modports: slave = scaler side, master = row producer / result consumer side.
interface bicubic_line_scaler_if #(
  parameter int PIX_W  = 8,
  parameter int MAX_SW = 32,
  parameter int MAX_TW = 64
) ();
  localparam int SW_W = $clog2(MAX_SW + 1);
  localparam int TW_W = $clog2(MAX_TW + 1);

  logic             start;
  logic [SW_W-1:0]  cfg_sw;
  logic [TW_W-1:0]  cfg_tw;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport slave (
    input  start, cfg_sw, cfg_tw, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done, cfg_err
  );

  modport master (
    output start, cfg_sw, cfg_tw, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done, cfg_err
  );
endinterface

// File: rtl/bicubic_line_scaler.sv
// rtl/bicubic_line_scaler.sv - 1-D bicubic/bilinear line scaler
// Purpose: buffers one source row of SW pixels, then emits TW interpolated
//          pixels at source positions x = k*(SW-1)/(TW-1), Catmull-Rom
//          (mode=0) or bilinear (mode=1).
// Ports:   CLK  rising-edge clock
//          RST  synchronous active-high reset
//          bus  bicubic_line_scaler_if.slave (config, pixel in/out streams, status)
module bicubic_line_scaler #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 16,
  parameter int MAX_SW = 32,
  parameter int MAX_TW = 64
) (
  input logic                  CLK,
  input logic                  RST,
  bicubic_line_scaler_if.slave bus
);
  localparam int SW_W  = $clog2(MAX_SW + 1);
  localparam int TW_W  = $clog2(MAX_TW + 1);
  localparam int BA_W  = $clog2(MAX_SW);
  localparam int RW    = $clog2(MAX_SW + MAX_TW + 1);
  localparam int CW    = PIX_W + 4;
  localparam int AW    = PIX_W + 5 + FRAC_W;
  localparam int CNT_W = $clog2((FRAC_W > 4) ? FRAC_W : 4);
  localparam logic [AW-1:0] RND = {{(AW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [AW-1:0] PIX_MAX = AW'((2**PIX_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_DIV, S_CALC, S_OUT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [PIX_W-1:0]     line_buf [MAX_SW];
  logic [SW_W-1:0]      sw_m1_q, n_q, idx_q;
  logic [TW_W-1:0]      tw_m1_q, k_q, div_r_q;
  logic                 mode_q, added_q, cfg_err_q;
  logic [RW-1:0]        rem_q;
  logic [FRAC_W-1:0]    t_q;
  logic [CNT_W-1:0]     cnt_q;
  logic signed [AW-1:0] acc_q;
  logic [PIX_W-1:0]     out_data_q;

  logic cfg_legal;
  assign cfg_legal = (bus.cfg_sw >= SW_W'(2)) && (bus.cfg_sw <= SW_W'(MAX_SW)) &&
                     (bus.cfg_tw >= TW_W'(2)) && (bus.cfg_tw <= TW_W'(MAX_TW));

  // Tap indices with edge replication.
  logic [SW_W-1:0] i0, i2, i3;
  logic [SW_W:0]   ip1, ip2;
  always_comb begin
    ip1 = {1'b0, idx_q} + 1'b1;
    ip2 = {1'b0, idx_q} + 2'd2;
    i0  = (idx_q == '0) ? '0 : idx_q - 1'b1;
    i2  = (ip1 > {1'b0, sw_m1_q}) ? sw_m1_q : ip1[SW_W-1:0];
    i3  = (ip2 > {1'b0, sw_m1_q}) ? sw_m1_q : ip2[SW_W-1:0];
  end

  // Coefficients are held as twice their value (1 fractional bit).
  logic signed [CW-1:0] s0, s1, s2, s3, ca, cb, cc, cd, coef;
  always_comb begin
    s0 = $signed({4'b0, line_buf[i0[BA_W-1:0]]});
    s1 = $signed({4'b0, line_buf[idx_q[BA_W-1:0]]});
    s2 = $signed({4'b0, line_buf[i2[BA_W-1:0]]});
    s3 = $signed({4'b0, line_buf[i3[BA_W-1:0]]});
    if (mode_q) begin
      ca = '0;
      cb = '0;
      cc = (s2 - s1) <<< 1;
    end else begin
      ca = s3 - s0 + (s1 - s2) + ((s1 - s2) <<< 1);
      cb = (s0 <<< 1) - (s1 <<< 2) - s1 + (s2 <<< 2) - s3;
      cc = s2 - s0;
    end
    cd = s1 <<< 1;
    case (cnt_q[1:0])
      2'd0:    coef = ca;
      2'd1:    coef = cb;
      2'd2:    coef = cc;
      default: coef = cd;
    endcase
  end

  // Horner step: product truncated back to FRAC_W fraction bits, then
  // round half-up and clamp to the pixel range.
  logic signed [AW+FRAC_W:0] prod;
  logic signed [AW-1:0]      prod_sh, coef_ext, acc_next, acc_rnd, rnd_int;
  logic [PIX_W-1:0]          pix;
  logic [TW_W:0]             div_sh;
  always_comb begin
    coef_ext = $signed({{(AW-CW){coef[CW-1]}}, coef}) <<< (FRAC_W - 1);
    prod     = acc_q * $signed({1'b0, t_q});
    prod_sh  = AW'(prod >>> FRAC_W);
    acc_next = (cnt_q == '0) ? coef_ext : prod_sh + coef_ext;
    acc_rnd  = acc_next + $signed(RND);
    rnd_int  = acc_rnd >>> FRAC_W;
    if (rnd_int[AW-1])          pix = '0;
    else if (rnd_int > PIX_MAX) pix = '1;
    else                        pix = rnd_int[PIX_W-1:0];
    div_sh   = {div_r_q, 1'b0};
  end

  logic in_ready_c, out_valid_c, busy_c, done_c;
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    done_c      = 1'b0;
    busy_c      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (bus.start && cfg_legal) state_d = S_LOAD;
      S_LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && n_q == sw_m1_q) state_d = S_STEP;
      end
      S_STEP: if (added_q && rem_q < RW'(tw_m1_q)) state_d = S_DIV;
      S_DIV:  if (cnt_q == CNT_W'(FRAC_W - 1)) state_d = S_CALC;
      S_CALC: if (cnt_q == CNT_W'(3)) state_d = S_OUT;
      S_OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = (k_q == tw_m1_q) ? S_DONE : S_STEP;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_LOAD && bus.in_valid) line_buf[n_q[BA_W-1:0]] <= bus.in_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_m1_q <= '0; tw_m1_q <= '0; mode_q <= 1'b0; n_q <= '0; k_q <= '0;
      idx_q <= '0; rem_q <= '0; added_q <= 1'b0; div_r_q <= '0; t_q <= '0;
      cnt_q <= '0; acc_q <= '0; out_data_q <= '0; cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          if (cfg_legal) begin
            sw_m1_q <= bus.cfg_sw - 1'b1;
            tw_m1_q <= bus.cfg_tw - 1'b1;
            mode_q  <= bus.mode;
            n_q     <= '0;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
        S_LOAD: if (bus.in_valid) begin
          n_q <= n_q + 1'b1;
          if (n_q == sw_m1_q) begin
            k_q     <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            added_q <= 1'b1;  // k=0 starts at x=0, no add
          end
        end
        S_STEP: begin
          if (!added_q) begin
            rem_q   <= rem_q + RW'(sw_m1_q);
            added_q <= 1'b1;
          end else if (rem_q >= RW'(tw_m1_q)) begin
            rem_q <= rem_q - RW'(tw_m1_q);
            idx_q <= idx_q + 1'b1;
          end else begin
            div_r_q <= rem_q[TW_W-1:0];
            t_q     <= '0;
            cnt_q   <= '0;
          end
        end
        S_DIV: begin
          // rem < TW-1, so the quotient fits entirely in FRAC_W bits.
          if (div_sh >= {1'b0, tw_m1_q}) begin
            div_r_q <= TW_W'(div_sh - {1'b0, tw_m1_q});
            t_q     <= {t_q[FRAC_W-2:0], 1'b1};
          end else begin
            div_r_q <= div_sh[TW_W-1:0];
            t_q     <= {t_q[FRAC_W-2:0], 1'b0};
          end
          cnt_q <= (cnt_q == CNT_W'(FRAC_W - 1)) ? '0 : cnt_q + 1'b1;
        end
        S_CALC: begin
          acc_q <= acc_next;
          if (cnt_q == CNT_W'(3)) begin
            out_data_q <= pix;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OUT: if (bus.out_ready && k_q != tw_m1_q) begin
          k_q     <= k_q + 1'b1;
          added_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.cfg_err   = cfg_err_q;
endmodule
